// File: rtl/shifter.sv
// shifter: single-position shift unit with a combinational result (sout)
// and a registered copy (sout_q / out_valid) captured on in_valid.
// Operations: 00 pass, 01 shift left, 10 logical right, 11 arithmetic right.
// Optional build macro SHIFTER_FLAGS_EN adds registered zero_q / neg_q flags
// describing the captured result.
module shifter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       shift,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sout,
    output logic [WIDTH-1:0] sout_q,
`ifdef SHIFTER_FLAGS_EN
    output logic             zero_q,
    output logic             neg_q,
`endif
    output logic             out_valid
);

    logic [WIDTH-1:0] sout_d;
    logic [WIDTH-1:0] sout_reg_d;
    logic             valid_d;
    logic             valid_q;

    // Combinational shift result; X on shift is not meaningfully resolved.
    always_comb begin
        sout_d = in;
        case (shift)
            2'b00:   sout_d = in;
            2'b01:   sout_d = {in[WIDTH-2:0], 1'b0};
            2'b10:   sout_d = {1'b0, in[WIDTH-1:1]};
            default: sout_d = {in[WIDTH-1], in[WIDTH-1:1]};
        endcase
    end

    assign sout = sout_d;

    // Next-state for the registered path: load on in_valid, otherwise hold.
    always_comb begin
        sout_reg_d = sout_q;
        valid_d    = in_valid;
        if (in_valid) begin
            sout_reg_d = sout_d;
        end
    end

    // Result register and valid flag; reset forces both to zero immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sout_q  <= sout_reg_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;

`ifdef SHIFTER_FLAGS_EN
    logic zero_d;
    logic neg_d;

    // Flags follow the value being captured and hold between captures.
    always_comb begin
        zero_d = zero_q;
        neg_d  = neg_q;
        if (in_valid) begin
            zero_d = (sout_d == '0);
            neg_d  = sout_d[WIDTH-1];
        end
    end

    // Flag registers share the result register's reset behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end
`endif

endmodule

// File: tb/tb_shifter.sv
// Directed bench for shifter (WIDTH=16): combinational vectors, registered
// capture/hold/back-to-back behaviour, and asynchronous reset.
module tb_shifter;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic [1:0]  shift;
    logic        in_valid;
    logic [15:0] sout;
    logic [15:0] sout_q;
    logic        out_valid;
`ifdef SHIFTER_FLAGS_EN
    logic        zero_q;
    logic        neg_q;
`endif

    int n_cmp;
    int n_bad;

    shifter #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .shift    (shift),
        .in_valid (in_valid),
        .sout     (sout),
        .sout_q   (sout_q),
`ifdef SHIFTER_FLAGS_EN
        .zero_q   (zero_q),
        .neg_q    (neg_q),
`endif
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        in       = 16'h0000;
        shift    = 2'b00;
        in_valid = 1'b0;

        // Reset state, before any clock edge
        #1;
        check("rst_sout_q", sout_q, 16'h0000);
        check("rst_valid", {15'd0, out_valid}, 16'd0);
`ifdef SHIFTER_FLAGS_EN
        check("rst_zero", {15'd0, zero_q}, 16'd0);
        check("rst_neg", {15'd0, neg_q}, 16'd0);
`endif
        // sout follows inputs while in reset
        in = 16'h00F0; shift = 2'b01; #1;
        check("sout_in_reset", sout, 16'h01E0);

        @(negedge clk);
        rst_n = 1'b1;

        // Combinational vectors
        in = 16'hABCD; shift = 2'b00; #1; check("pass_ABCD", sout, 16'hABCD);
        in = 16'hFF1D; shift = 2'b01; #1; check("shl_FF1D", sout, 16'hFE3A);
        in = 16'hFF1D; shift = 2'b10; #1; check("lsr_FF1D", sout, 16'h7F8E);
        in = 16'hFF1D; shift = 2'b11; #1; check("asr_FF1D", sout, 16'hFF8E);
        in = 16'h7FFF; shift = 2'b11; #1; check("asr_7FFF", sout, 16'h3FFF);
        in = 16'h8001; shift = 2'b10; #1; check("lsr_8001", sout, 16'h4000);
        in = 16'h8001; shift = 2'b11; #1; check("asr_8001", sout, 16'hC000);
        in = 16'h8001; shift = 2'b01; #1; check("shl_8001", sout, 16'h0002);

        // No capture yet after reset release
        check("no_cap_valid", {15'd0, out_valid}, 16'd0);

        // Capture 8001 << 1
        @(negedge clk);
        in = 16'h8001; shift = 2'b01; in_valid = 1'b1;
        @(posedge clk); #1;
        check("cap1_sout_q", sout_q, 16'h0002);
        check("cap1_valid", {15'd0, out_valid}, 16'd1);
`ifdef SHIFTER_FLAGS_EN
        check("cap1_zero", {15'd0, zero_q}, 16'd0);
        check("cap1_neg", {15'd0, neg_q}, 16'd0);
`endif

        // Hold when in_valid is low
        @(negedge clk);
        in_valid = 1'b0; in = 16'hFFFF; shift = 2'b00;
        @(posedge clk); #1;
        check("hold_sout_q", sout_q, 16'h0002);
        check("hold_valid", {15'd0, out_valid}, 16'd0);

        // Back-to-back captures
        @(negedge clk);
        in_valid = 1'b1; in = 16'h8000; shift = 2'b00;
        @(posedge clk); #1;
        check("b2b1_sout_q", sout_q, 16'h8000);
        check("b2b1_valid", {15'd0, out_valid}, 16'd1);
`ifdef SHIFTER_FLAGS_EN
        check("b2b1_zero", {15'd0, zero_q}, 16'd0);
        check("b2b1_neg", {15'd0, neg_q}, 16'd1);
`endif
        @(negedge clk);
        in = 16'h0001; shift = 2'b10;
        @(posedge clk); #1;
        check("b2b2_sout_q", sout_q, 16'h0000);
        check("b2b2_valid", {15'd0, out_valid}, 16'd1);
`ifdef SHIFTER_FLAGS_EN
        check("b2b2_zero", {15'd0, zero_q}, 16'd1);
        check("b2b2_neg", {15'd0, neg_q}, 16'd0);
`endif
        @(negedge clk);
        in = 16'h1234; shift = 2'b01;
        @(posedge clk); #1;
        check("b2b3_sout_q", sout_q, 16'h2468);
        check("b2b3_valid", {15'd0, out_valid}, 16'd1);

        // Mid-cycle asynchronous reset, in_valid still high
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_sout_q", sout_q, 16'h0000);
        check("arst_valid", {15'd0, out_valid}, 16'd0);
`ifdef SHIFTER_FLAGS_EN
        check("arst_zero", {15'd0, zero_q}, 16'd0);
        check("arst_neg", {15'd0, neg_q}, 16'd0);
`endif
        in = 16'h00F0; shift = 2'b10; #1;
        check("arst_sout", sout, 16'h0078);

        // Reset wins over in_valid at a clock edge
        @(posedge clk); #1;
        check("rprio_sout_q", sout_q, 16'h0000);
        check("rprio_valid", {15'd0, out_valid}, 16'd0);

        // Release with in_valid low: no capture
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        check("rel_sout_q", sout_q, 16'h0000);
        check("rel_valid", {15'd0, out_valid}, 16'd0);

        // First capture after release
        @(negedge clk);
        in_valid = 1'b1; in = 16'h0003; shift = 2'b11;
        @(posedge clk); #1;
        check("first_sout_q", sout_q, 16'h0001);
        check("first_valid", {15'd0, out_valid}, 16'd1);

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("last_valid", {15'd0, out_valid}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
